// File: rtl/bgpu_pkg.sv
// bgpu_pkg: compute-unit configuration and shared types for the warp
// dispatcher and its slot table.
//   Cfg*          default compute-unit dimensions; the slot table is sized
//                 directly from these, so the dispatcher parameters must
//                 keep their defaults
//   launch_req_t  one block launch request as presented on the launch port
//   slot_entry_t  one tracked block: valid, tag and the warps it owns
//   slot_idx_t    index into the slot table
//   disp_state_e  dispatcher FSM states
package bgpu_pkg;

  localparam int unsigned CfgPcWidth    = 32;
  localparam int unsigned CfgNumWarps   = 8;
  localparam int unsigned CfgWarpWidth  = 32;
  localparam int unsigned CfgNumBlocks  = 4;
  localparam int unsigned CfgBidWidth   = 8;
  localparam int unsigned CfgWidWidth   = $clog2(CfgNumWarps);
  localparam int unsigned CfgSlotWidth  = $clog2(CfgNumBlocks);

  typedef logic [CfgSlotWidth-1:0] slot_idx_t;

  typedef struct packed {
    logic [CfgPcWidth-1:0]   pc;
    logic [CfgWidWidth:0]    num_warps;
    logic [CfgWarpWidth-1:0] last_mask;
    logic [CfgBidWidth-1:0]  block_id;
  } launch_req_t;

  typedef struct packed {
    logic                   valid;
    logic [CfgBidWidth-1:0] block_id;
    logic [CfgNumWarps-1:0] warp_mask;
  } slot_entry_t;

  typedef enum logic {
    IDLE,
    DISPATCH
  } disp_state_e;

endpackage

// File: rtl/dispatch_slot_table.sv
// dispatch_slot_table: storage for the concurrently tracked blocks plus
// completion detection and lowest-index selection.
//   alloc_i / alloc_block_id_i   claim the lowest free slot (free_slot_o)
//   set_i / set_slot_i / set_wid_i  add one warp to a slot; a slot being
//                                set is still being dispatched and is never
//                                reported complete
//   release_i / release_slot_i   invalidate a slot after its done handshake
//   warp_stopped_i               per-warp stopped status
//   free_avail_o / free_slot_o   lowest invalid slot
//   complete_avail_o / complete_slot_o / complete_block_id_o
//                                lowest complete slot and its tag
//   release_mask_o               warp mask of release_slot_i
//   any_valid_o                  at least one slot is in use
module dispatch_slot_table
  import bgpu_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   alloc_i,
  input  logic [CfgBidWidth-1:0] alloc_block_id_i,
  input  logic                   set_i,
  input  slot_idx_t              set_slot_i,
  input  logic [CfgWidWidth-1:0] set_wid_i,
  input  logic                   release_i,
  input  slot_idx_t              release_slot_i,
  input  logic [CfgNumWarps-1:0] warp_stopped_i,
  output logic                   free_avail_o,
  output slot_idx_t              free_slot_o,
  output logic                   complete_avail_o,
  output slot_idx_t              complete_slot_o,
  output logic [CfgBidWidth-1:0] complete_block_id_o,
  output logic [CfgNumWarps-1:0] release_mask_o,
  output logic                   any_valid_o
);

  logic [CfgNumBlocks-1:0] valid_vec;
  logic [CfgNumBlocks-1:0] complete_vec;
  logic [CfgNumWarps-1:0]  mask_arr [CfgNumBlocks];
  logic [CfgBidWidth-1:0]  bid_arr  [CfgNumBlocks];

  for (genvar gi = 0; gi < CfgNumBlocks; gi++) begin : g_slot
    slot_entry_t entry_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        entry_reg <= '0;
      end else if (alloc_i && (free_slot_o == slot_idx_t'(gi))) begin
        entry_reg.valid     <= 1'b1;
        entry_reg.block_id  <= alloc_block_id_i;
        entry_reg.warp_mask <= '0;
      end else begin
        if (set_i && (set_slot_i == slot_idx_t'(gi)))
          entry_reg.warp_mask[set_wid_i] <= 1'b1;
        if (release_i && (release_slot_i == slot_idx_t'(gi)))
          entry_reg.valid <= 1'b0;
      end
    end

    assign valid_vec[gi] = entry_reg.valid;
    assign mask_arr[gi]  = entry_reg.warp_mask;
    assign bid_arr[gi]   = entry_reg.block_id;
    // Stopped bits outside the mask (free or foreign warps) are masked away.
    assign complete_vec[gi] = entry_reg.valid
                            && !(set_i && (set_slot_i == slot_idx_t'(gi)))
                            && ((warp_stopped_i & entry_reg.warp_mask) == entry_reg.warp_mask);
  end

  // Descending scan so the lowest index wins.
  always_comb begin
    free_avail_o     = 1'b0;
    free_slot_o      = '0;
    complete_avail_o = 1'b0;
    complete_slot_o  = '0;
    for (int i = CfgNumBlocks - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_avail_o = 1'b1;
        free_slot_o  = slot_idx_t'(i);
      end
      if (complete_vec[i]) begin
        complete_avail_o = 1'b1;
        complete_slot_o  = slot_idx_t'(i);
      end
    end
  end

  assign complete_block_id_o = bid_arr[complete_slot_o];
  assign release_mask_o      = mask_arr[release_slot_i];
  assign any_valid_o         = |valid_vec;

endmodule

// File: rtl/warp_dispatcher.sv
// warp_dispatcher: thread-block launch controller in front of the fetcher's
// reconvergence stack. Accepts block launches, initialises one free warp per
// cycle for the accepted block, reports completed blocks upstream and then
// releases their warps.
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   launch_*               launch request handshake and payload
//   init_*                 warp-init pulse (wid, pc, active mask)
//   warp_stopped_i         per-warp stopped status
//   warp_release_o         one-cycle pulse of warps freed on a done handshake
//   done_*                 completed-block handshake and tag
//   busy_o                 any block tracked or dispatch in progress
//   error_o                sticky, set by an illegal warp count
module warp_dispatcher
  import bgpu_pkg::*;
#(
  parameter int unsigned PcWidth   = CfgPcWidth,
  parameter int unsigned NumWarps  = CfgNumWarps,
  parameter int unsigned WarpWidth = CfgWarpWidth,
  parameter int unsigned NumBlocks = CfgNumBlocks,
  parameter int unsigned BidWidth  = CfgBidWidth,
  parameter int unsigned WidWidth  = $clog2(NumWarps)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 launch_valid_i,
  output logic                 launch_ready_o,
  input  logic [PcWidth-1:0]   launch_pc_i,
  input  logic [WidWidth:0]    launch_num_warps_i,
  input  logic [WarpWidth-1:0] launch_last_mask_i,
  input  logic [BidWidth-1:0]  launch_block_id_i,
  output logic                 init_valid_o,
  output logic [WidWidth-1:0]  init_wid_o,
  output logic [PcWidth-1:0]   init_pc_o,
  output logic [WarpWidth-1:0] init_act_mask_o,
  input  logic [NumWarps-1:0]  warp_stopped_i,
  output logic [NumWarps-1:0]  warp_release_o,
  output logic                 done_valid_o,
  input  logic                 done_ready_i,
  output logic [BidWidth-1:0]  done_block_id_o,
  output logic                 busy_o,
  output logic                 error_o
);

  disp_state_e          state_reg;
  logic [WidWidth:0]    remaining_reg;
  logic [PcWidth-1:0]   pc_reg;
  logic [WarpWidth-1:0] last_mask_reg;
  slot_idx_t            slot_idx_reg;
  logic [NumWarps-1:0]  free_reg, free_next;
  logic                 error_reg;
  logic                 done_valid_reg;
  logic [BidWidth-1:0]  done_block_id_reg;
  slot_idx_t            done_slot_reg;

  launch_req_t          req;
  logic [WidWidth-1:0]  pick_wid;
  logic [WidWidth:0]    free_cnt;
  logic                 num_legal, accept, dispatching, last_issue, done_hs;
  logic [NumWarps-1:0]  issue_onehot;

  logic                 free_avail, complete_avail, any_valid;
  slot_idx_t            free_slot, complete_slot;
  logic [BidWidth-1:0]  complete_block_id;
  logic [NumWarps-1:0]  release_mask;

  assign req = '{pc: launch_pc_i, num_warps: launch_num_warps_i,
                 last_mask: launch_last_mask_i, block_id: launch_block_id_i};

  // Lowest free warp and number of free warps.
  always_comb begin
    pick_wid = '0;
    free_cnt = '0;
    for (int i = NumWarps - 1; i >= 0; i--) begin
      if (free_reg[i]) begin
        pick_wid = WidWidth'(i);
        free_cnt = free_cnt + 1'b1;
      end
    end
  end

  assign num_legal   = (req.num_warps != '0) && (req.num_warps <= (WidWidth+1)'(NumWarps));
  // Uses pre-release state: warps freed by this cycle's handshake count next cycle.
  // Gated by rst_ni so the port reads 0 while reset is held.
  assign launch_ready_o = rst_ni && (state_reg == IDLE) && free_avail
                        && (!num_legal || (free_cnt >= req.num_warps));
  assign accept      = launch_valid_i && launch_ready_o;

  assign dispatching  = (state_reg == DISPATCH);
  assign last_issue   = (remaining_reg == (WidWidth+1)'(1));
  assign issue_onehot = dispatching ? (NumWarps'(1) << pick_wid) : '0;

  assign init_valid_o    = dispatching;
  assign init_wid_o      = dispatching ? pick_wid : '0;
  assign init_pc_o       = dispatching ? pc_reg : '0;
  assign init_act_mask_o = !dispatching ? '0 : (last_issue ? last_mask_reg : '1);

  assign done_hs         = done_valid_reg && done_ready_i;
  assign warp_release_o  = done_hs ? release_mask : '0;
  assign done_valid_o    = done_valid_reg;
  assign done_block_id_o = done_block_id_reg;
  assign error_o         = error_reg;
  assign busy_o          = any_valid || (state_reg != IDLE);

  assign free_next = (free_reg & ~issue_onehot) | warp_release_o;

  dispatch_slot_table u_slot_table (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .alloc_i             (accept && num_legal),
    .alloc_block_id_i    (req.block_id),
    .set_i               (dispatching),
    .set_slot_i          (slot_idx_reg),
    .set_wid_i           (pick_wid),
    .release_i           (done_hs),
    .release_slot_i      (done_slot_reg),
    .warp_stopped_i      (warp_stopped_i),
    .free_avail_o        (free_avail),
    .free_slot_o         (free_slot),
    .complete_avail_o    (complete_avail),
    .complete_slot_o     (complete_slot),
    .complete_block_id_o (complete_block_id),
    .release_mask_o      (release_mask),
    .any_valid_o         (any_valid)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg         <= IDLE;
      remaining_reg     <= '0;
      pc_reg            <= '0;
      last_mask_reg     <= '0;
      slot_idx_reg      <= '0;
      free_reg          <= '1;
      error_reg         <= 1'b0;
      done_valid_reg    <= 1'b0;
      done_block_id_reg <= '0;
      done_slot_reg     <= '0;
    end else begin
      free_reg <= free_next;

      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (!num_legal) begin
              error_reg <= 1'b1;
            end else begin
              state_reg     <= DISPATCH;
              remaining_reg <= req.num_warps;
              pc_reg        <= req.pc;
              // A zero last mask stands for a full final warp.
              last_mask_reg <= (req.last_mask == '0) ? '1 : req.last_mask;
              slot_idx_reg  <= free_slot;
            end
          end
        end
        DISPATCH: begin
          remaining_reg <= remaining_reg - 1'b1;
          if (last_issue)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      // Loading only into an empty register means a complete slot, which stays
      // valid until its handshake, is reported exactly once.
      if (done_hs) begin
        done_valid_reg <= 1'b0;
      end else if (!done_valid_reg && complete_avail) begin
        done_valid_reg    <= 1'b1;
        done_block_id_reg <= complete_block_id;
        done_slot_reg     <= complete_slot;
      end
    end
  end

endmodule

// File: tb/tb_warp_dispatcher.sv
module tb_warp_dispatcher;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        launch_valid_i = 1'b0;
  logic        launch_ready_o;
  logic [31:0] launch_pc_i = '0;
  logic [3:0]  launch_num_warps_i = '0;
  logic [31:0] launch_last_mask_i = '0;
  logic [7:0]  launch_block_id_i = '0;
  logic        init_valid_o;
  logic [2:0]  init_wid_o;
  logic [31:0] init_pc_o;
  logic [31:0] init_act_mask_o;
  logic [7:0]  warp_stopped_i = '0;
  logic [7:0]  warp_release_o;
  logic        done_valid_o;
  logic        done_ready_i = 1'b0;
  logic [7:0]  done_block_id_o;
  logic        busy_o;
  logic        error_o;

  int checks_total  = 0;
  int checks_passed = 0;

  warp_dispatcher dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .launch_valid_i     (launch_valid_i),
    .launch_ready_o     (launch_ready_o),
    .launch_pc_i        (launch_pc_i),
    .launch_num_warps_i (launch_num_warps_i),
    .launch_last_mask_i (launch_last_mask_i),
    .launch_block_id_i  (launch_block_id_i),
    .init_valid_o       (init_valid_o),
    .init_wid_o         (init_wid_o),
    .init_pc_o          (init_pc_o),
    .init_act_mask_o    (init_act_mask_o),
    .warp_stopped_i     (warp_stopped_i),
    .warp_release_o     (warp_release_o),
    .done_valid_o       (done_valid_o),
    .done_ready_i       (done_ready_i),
    .done_block_id_o    (done_block_id_o),
    .busy_o             (busy_o),
    .error_o            (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
      $display("check %-14s got=%0h exp=%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks happen 3ns after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    launch_valid_i = 1'b0;
    done_ready_i = 1'b0;
    warp_stopped_i = '0;
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  // Presents a launch for one cycle and expects it to be accepted.
  task automatic launch(input logic [31:0] pc, input logic [3:0] n,
                        input logic [31:0] lmask, input logic [7:0] bid);
    launch_valid_i     = 1'b1;
    launch_pc_i        = pc;
    launch_num_warps_i = n;
    launch_last_mask_i = lmask;
    launch_block_id_i  = bid;
    settle();
    check_eq("launch_ready", launch_ready_o, 1'b1);
    step();
    launch_valid_i = 1'b0;
  endtask

  task automatic expect_init(input logic [2:0] wid, input logic [31:0] pc, input logic [31:0] mask);
    settle();
    check_eq("init_valid", init_valid_o, 1'b1);
    check_eq("init_wid", init_wid_o, wid);
    check_eq("init_pc", init_pc_o, pc);
    check_eq("init_mask", init_act_mask_o, mask);
    step();
  endtask

  initial begin
    // Outputs while reset is held.
    #2;
    check_eq("rst_ready", launch_ready_o, 1'b0);
    check_eq("rst_init", init_valid_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_done", done_valid_o, 1'b0);
    check_eq("rst_error", error_o, 1'b0);
    check_eq("rst_release", warp_release_o, 8'h00);
    step();
    rst_ni = 1'b1;
    step();

    // Three-warp block with a partial final mask.
    launch(32'h100, 4'd3, 32'h0000FFFF, 8'd1);
    expect_init(3'd0, 32'h100, 32'hFFFFFFFF);
    expect_init(3'd1, 32'h100, 32'hFFFFFFFF);
    expect_init(3'd2, 32'h100, 32'h0000FFFF);
    settle();
    check_eq("init_idle", init_valid_o, 1'b0);
    check_eq("busy_block1", busy_o, 1'b1);

    // Retire block 1.
    warp_stopped_i = 8'b0000_0111;
    step();
    settle();
    check_eq("done1_valid", done_valid_o, 1'b1);
    check_eq("done1_id", done_block_id_o, 8'd1);
    done_ready_i = 1'b1;
    settle();
    check_eq("release1", warp_release_o, 8'b0000_0111);
    step();
    done_ready_i = 1'b0;
    warp_stopped_i = '0;
    settle();
    check_eq("busy_after1", busy_o, 1'b0);

    // Block 5 on warps {0,1}; zero last mask means all-ones.
    launch(32'h200, 4'd2, 32'h0, 8'd5);
    expect_init(3'd0, 32'h200, 32'hFFFFFFFF);
    expect_init(3'd1, 32'h200, 32'hFFFFFFFF);
    warp_stopped_i = 8'b0000_0001;
    step();
    step();
    settle();
    check_eq("done5_partial", done_valid_o, 1'b0);
    warp_stopped_i = 8'b0000_0011;
    step();
    settle();
    check_eq("done5_valid", done_valid_o, 1'b1);
    check_eq("done5_id", done_block_id_o, 8'd5);
    done_ready_i = 1'b1;
    settle();
    check_eq("release5", warp_release_o, 8'b0000_0011);
    step();
    done_ready_i = 1'b0;
    warp_stopped_i = '0;
    settle();
    check_eq("busy_after5", busy_o, 1'b0);
    check_eq("done5_cleared", done_valid_o, 1'b0);

    // Six warps busy, a four-warp request must wait for a release.
    launch(32'h300, 4'd2, 32'h0, 8'd10);
    expect_init(3'd0, 32'h300, 32'hFFFFFFFF);
    expect_init(3'd1, 32'h300, 32'hFFFFFFFF);
    launch(32'h400, 4'd4, 32'h0, 8'd11);
    for (int k = 0; k < 4; k++) expect_init(3'(k + 2), 32'h400, 32'hFFFFFFFF);
    launch_valid_i     = 1'b1;
    launch_pc_i        = 32'h500;
    launch_num_warps_i = 4'd4;
    launch_last_mask_i = 32'h0000000F;
    launch_block_id_i  = 8'd12;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_eq("nofit_ready", launch_ready_o, 1'b0);
      step();
    end
    warp_stopped_i = 8'b0000_0011;
    step();
    settle();
    check_eq("done10_id", done_block_id_o, 8'd10);
    check_eq("nofit_wait", launch_ready_o, 1'b0);
    done_ready_i = 1'b1;
    settle();
    check_eq("hs_ready_pre", launch_ready_o, 1'b0);
    check_eq("release10", warp_release_o, 8'b0000_0011);
    step();
    done_ready_i = 1'b0;
    settle();
    check_eq("fit_ready", launch_ready_o, 1'b1);
    step();
    launch_valid_i = 1'b0;
    warp_stopped_i = '0;
    expect_init(3'd0, 32'h500, 32'hFFFFFFFF);
    expect_init(3'd1, 32'h500, 32'hFFFFFFFF);
    expect_init(3'd6, 32'h500, 32'hFFFFFFFF);
    expect_init(3'd7, 32'h500, 32'h0000000F);

    // Fill all four slots with one-warp blocks.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      launch(32'h600, 4'd1, 32'h0, 8'(20 + k));
      expect_init(3'(k), 32'h600, 32'hFFFFFFFF);
    end
    launch_valid_i     = 1'b1;
    launch_num_warps_i = 4'd1;
    settle();
    check_eq("slots_full", launch_ready_o, 1'b0);
    launch_valid_i = 1'b0;
    // Slots 1 and 2 complete together.
    warp_stopped_i = 8'b0000_0110;
    step();
    settle();
    check_eq("dual_valid", done_valid_o, 1'b1);
    check_eq("dual_first", done_block_id_o, 8'd21);
    for (int k = 0; k < 5; k++) begin
      step();
      settle();
      check_eq("hold_valid", done_valid_o, 1'b1);
      check_eq("hold_id", done_block_id_o, 8'd21);
    end
    done_ready_i = 1'b1;
    settle();
    check_eq("release21", warp_release_o, 8'b0000_0010);
    step();
    done_ready_i = 1'b0;
    settle();
    check_eq("gap_valid", done_valid_o, 1'b0);
    step();
    settle();
    check_eq("dual_second", done_block_id_o, 8'd22);
    check_eq("second_valid", done_valid_o, 1'b1);
    done_ready_i = 1'b1;
    settle();
    check_eq("release22", warp_release_o, 8'b0000_0100);
    step();
    done_ready_i = 1'b0;
    warp_stopped_i = '0;

    // Illegal warp counts.
    launch(32'h700, 4'd0, 32'h0, 8'd30);
    settle();
    check_eq("err_zero", error_o, 1'b1);
    check_eq("err_noinit0", init_valid_o, 1'b0);
    launch(32'h700, 4'd9, 32'h0, 8'd31);
    settle();
    check_eq("err_nine", error_o, 1'b1);
    check_eq("err_noinit9", init_valid_o, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      settle();
      check_eq("err_sticky", error_o, 1'b1);
      check_eq("err_nodone", done_valid_o, 1'b0);
      check_eq("err_noinit", init_valid_o, 1'b0);
    end

    // Reset in the middle of a dispatch.
    do_reset();
    launch(32'h800, 4'd4, 32'h0, 8'd40);
    expect_init(3'd0, 32'h800, 32'hFFFFFFFF);
    expect_init(3'd1, 32'h800, 32'hFFFFFFFF);
    rst_ni = 1'b0;
    settle();
    check_eq("mid_init", init_valid_o, 1'b0);
    check_eq("mid_busy", busy_o, 1'b0);
    check_eq("mid_ready", launch_ready_o, 1'b0);
    check_eq("mid_error", error_o, 1'b0);
    check_eq("mid_release", warp_release_o, 8'h00);
    step();
    rst_ni = 1'b1;
    step();
    launch(32'h900, 4'd8, 32'hAAAA5555, 8'd50);
    for (int k = 0; k < 7; k++) expect_init(3'(k), 32'h900, 32'hFFFFFFFF);
    expect_init(3'd7, 32'h900, 32'hAAAA5555);
    settle();
    check_eq("full_idle", init_valid_o, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
